// File: rtl/pe_pkg.sv
// pe_pkg: shared mode encodings and width sanity check for the weight-stationary PE.
package pe_pkg;
   localparam logic MODE_PASS  = 1'b0;
   localparam logic MODE_LOCAL = 1'b1;

   function automatic bit widths_ok(int dw, int aw);
      return aw >= 2 * dw;
   endfunction
endpackage

// File: rtl/pe_ws_dbuf_if.sv
// pe_ws_dbuf_if: data, psum and weight-chain signals of one PE; slave is the PE side.
interface pe_ws_dbuf_if #(parameter int DW = 16, parameter int AW = 40);
   logic [DW-1:0] x_in;
   logic          x_valid;
   logic [AW-1:0] psum_in;
   logic          acc_clr;
   logic          mode;
   logic [DW-1:0] w_in;
   logic          w_load;
   logic          w_swap;
   logic          ovf_clr;
   logic [DW-1:0] x_out;
   logic          x_valid_out;
   logic [DW-1:0] w_out;
   logic          w_swap_out;
   logic [AW-1:0] psum_out;
   logic          psum_valid_out;
   logic          ovf;

   modport slave (
      input  x_in, x_valid, psum_in, acc_clr, mode, w_in, w_load, w_swap, ovf_clr,
      output x_out, x_valid_out, w_out, w_swap_out, psum_out, psum_valid_out, ovf
   );
   modport master (
      output x_in, x_valid, psum_in, acc_clr, mode, w_in, w_load, w_swap, ovf_clr,
      input  x_out, x_valid_out, w_out, w_swap_out, psum_out, psum_valid_out, ovf
   );
endinterface

// File: rtl/pe_sat_add.sv
// pe_sat_add: AW-bit add with overflow detect and optional clamp to the representable range.
module pe_sat_add #(
   parameter int AW     = 40,
   parameter int SIGNED = 1,
   parameter int SAT    = 1
) (
   input  logic [AW-1:0] a,
   input  logic [AW-1:0] b,
   output logic [AW-1:0] sum,
   output logic          ovf
);
   logic [AW:0]   full;
   logic [AW-1:0] bound;

   // Signed overflow shows as a mismatch of the two top bits; its sign picks the bound.
   always_comb begin
      full  = (SIGNED != 0) ? {a[AW-1], a} + {b[AW-1], b} : {1'b0, a} + {1'b0, b};
      ovf   = (SIGNED != 0) ? full[AW] ^ full[AW-1] : full[AW];
      bound = (SIGNED != 0) ? {full[AW], {(AW-1){~full[AW]}}} : '1;
      sum   = (SAT != 0 && ovf) ? bound : full[AW-1:0];
   end
endmodule

// File: rtl/pe_ws_dbuf.sv
// pe_ws_dbuf: weight-stationary PE with shadow/active weights, 2-stage multiply-add,
// pass-through or local accumulation, and a sticky overflow flag.
module pe_ws_dbuf
   import pe_pkg::*;
#(
   parameter int DW     = 16,
   parameter int AW     = 40,
   parameter int SIGNED = 1,
   parameter int SAT    = 1
) (
   input logic         clk,
   input logic         rst_n,
   pe_ws_dbuf_if.slave p
);
   if (!widths_ok(DW, AW)) begin : g_width_chk
      $error("pe_ws_dbuf: AW must be at least 2*DW");
   end

   logic [DW-1:0]          shadow_q, shadow_d, active_q, active_d, x_q, x_d;
   logic                   xv_q, xv_d, swo_q, swo_d, clr_q, clr_d, v1_q, v1_d;
   logic                   pv_q, pv_d, ovf_q, ovf_d;
   logic [AW-1:0]          prod_q, prod_d, psum_r_q, psum_r_d, acc_q, acc_d, psum_q, psum_d;
   logic signed [2*DW-1:0] prod_s;
   logic [2*DW-1:0]        prod_u;
   logic [AW-1:0]          add_b, sum;
   logic                   sum_ovf;

   always_comb begin
      prod_s   = (2*DW)'($signed(p.x_in)) * (2*DW)'($signed(active_q));
      prod_u   = (2*DW)'(p.x_in) * (2*DW)'(active_q);
      prod_d   = (SIGNED != 0) ? AW'(prod_s) : AW'(prod_u);
      psum_r_d = p.psum_in;
      clr_d    = p.acc_clr;
      v1_d     = p.x_valid;
      x_d      = p.x_valid ? p.x_in : x_q;
      xv_d     = p.x_valid;
      swo_d    = p.w_swap;
      active_d = p.w_swap ? shadow_q : active_q;
      shadow_d = p.w_load ? p.w_in : shadow_q;
      add_b    = (p.mode == MODE_LOCAL) ? (clr_q ? '0 : acc_q) : psum_r_q;
      acc_d    = (p.mode != MODE_LOCAL) ? acc_q : v1_q ? sum : clr_q ? '0 : acc_q;
      psum_d   = v1_q ? sum : psum_q;
      pv_d     = v1_q;
      ovf_d    = (v1_q & sum_ovf) | (ovf_q & ~p.ovf_clr);
   end

   pe_sat_add #(.AW(AW), .SIGNED(SIGNED), .SAT(SAT)) u_add (
      .a   (prod_q),
      .b   (add_b),
      .sum (sum),
      .ovf (sum_ovf)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shadow_q <= '0;
         active_q <= '0;
         x_q      <= '0;
         xv_q     <= 1'b0;
         swo_q    <= 1'b0;
         clr_q    <= 1'b0;
         v1_q     <= 1'b0;
         prod_q   <= '0;
         psum_r_q <= '0;
         acc_q    <= '0;
         psum_q   <= '0;
         pv_q     <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
         x_q      <= x_d;
         xv_q     <= xv_d;
         swo_q    <= swo_d;
         clr_q    <= clr_d;
         v1_q     <= v1_d;
         prod_q   <= prod_d;
         psum_r_q <= psum_r_d;
         acc_q    <= acc_d;
         psum_q   <= psum_d;
         pv_q     <= pv_d;
         ovf_q    <= ovf_d;
      end
   end

   assign p.x_out          = x_q;
   assign p.x_valid_out    = xv_q;
   assign p.w_out          = shadow_q;
   assign p.w_swap_out     = swo_q;
   assign p.psum_out       = psum_q;
   assign p.psum_valid_out = pv_q;
   assign p.ovf            = ovf_q;
endmodule

// File: tb/tb_pe_ws_dbuf.sv
// tb_pe_ws_dbuf: directed scenarios plus randomized traffic checked against a beat-level model;
// a SAT=0 twin and a 3-PE weight chain share the same stimulus.
module tb_pe_ws_dbuf;
   localparam int DW = 8;
   localparam int AW = 20;
   localparam longint MAXV = (longint'(1) << (AW-1)) - 1;
   localparam longint MINV = -(longint'(1) << (AW-1));

   logic clk = 1'b0, rst_n = 1'b0;
   logic signed [DW-1:0] x_in = '0, w_in = '0;
   logic signed [AW-1:0] psum_in = '0;
   logic x_valid = 0, acc_clr = 0, mode = 0, w_load = 0, w_swap = 0, ovf_clr = 0;
   int n_chk = 0, n_err = 0;

   always #5 clk = ~clk;

   pe_ws_dbuf_if #(.DW(DW), .AW(AW)) m_if ();
   pe_ws_dbuf_if #(.DW(DW), .AW(AW)) w_if ();
   pe_ws_dbuf_if #(.DW(DW), .AW(AW)) c0_if ();
   pe_ws_dbuf_if #(.DW(DW), .AW(AW)) c1_if ();
   pe_ws_dbuf_if #(.DW(DW), .AW(AW)) c2_if ();

   assign m_if.x_in = x_in;    assign m_if.x_valid = x_valid; assign m_if.psum_in = psum_in;
   assign m_if.acc_clr = acc_clr; assign m_if.mode = mode;    assign m_if.w_in = w_in;
   assign m_if.w_load = w_load; assign m_if.w_swap = w_swap;  assign m_if.ovf_clr = ovf_clr;
   assign w_if.x_in = x_in;    assign w_if.x_valid = x_valid; assign w_if.psum_in = psum_in;
   assign w_if.acc_clr = acc_clr; assign w_if.mode = mode;    assign w_if.w_in = w_in;
   assign w_if.w_load = w_load; assign w_if.w_swap = w_swap;  assign w_if.ovf_clr = ovf_clr;
   assign c0_if.x_in = x_in;   assign c0_if.x_valid = x_valid; assign c0_if.psum_in = '0;
   assign c0_if.acc_clr = 1'b0; assign c0_if.mode = 1'b0;     assign c0_if.w_in = w_in;
   assign c0_if.w_load = w_load; assign c0_if.w_swap = w_swap; assign c0_if.ovf_clr = 1'b0;
   assign c1_if.x_in = x_in;   assign c1_if.x_valid = x_valid; assign c1_if.psum_in = '0;
   assign c1_if.acc_clr = 1'b0; assign c1_if.mode = 1'b0;     assign c1_if.w_in = c0_if.w_out;
   assign c1_if.w_load = w_load; assign c1_if.w_swap = w_swap; assign c1_if.ovf_clr = 1'b0;
   assign c2_if.x_in = x_in;   assign c2_if.x_valid = x_valid; assign c2_if.psum_in = '0;
   assign c2_if.acc_clr = 1'b0; assign c2_if.mode = 1'b0;     assign c2_if.w_in = c1_if.w_out;
   assign c2_if.w_load = w_load; assign c2_if.w_swap = w_swap; assign c2_if.ovf_clr = 1'b0;

   pe_ws_dbuf #(.DW(DW), .AW(AW), .SIGNED(1), .SAT(1)) u_dut  (.clk(clk), .rst_n(rst_n), .p(m_if));
   pe_ws_dbuf #(.DW(DW), .AW(AW), .SIGNED(1), .SAT(0)) u_wrap (.clk(clk), .rst_n(rst_n), .p(w_if));
   pe_ws_dbuf #(.DW(DW), .AW(AW), .SIGNED(1), .SAT(1)) u_c0   (.clk(clk), .rst_n(rst_n), .p(c0_if));
   pe_ws_dbuf #(.DW(DW), .AW(AW), .SIGNED(1), .SAT(1)) u_c1   (.clk(clk), .rst_n(rst_n), .p(c1_if));
   pe_ws_dbuf #(.DW(DW), .AW(AW), .SIGNED(1), .SAT(1)) u_c2   (.clk(clk), .rst_n(rst_n), .p(c2_if));

   // Beat-level model of the SAT=1 PE: each accepted beat is resolved with plain integer
   // arithmetic and presented one clock later than its stage-1 outputs.
   longint m_shadow, m_active, m_acc, m_xout, m_psum, m_res;
   bit     m_xv, m_swo, m_pv, m_ovf, m_p_v, m_p_ov;

   task automatic model_step();
      longint s, base;
      if (!rst_n) begin
         {m_shadow, m_active, m_acc, m_xout, m_psum, m_res} = '0;
         {m_xv, m_swo, m_pv, m_ovf, m_p_v, m_p_ov} = '0;
      end else begin
         m_pv = m_p_v;
         if (m_p_v) m_psum = m_res;
         m_ovf = m_p_ov || (m_ovf && !ovf_clr);
         m_p_v = x_valid;
         m_p_ov = 0;
         if (x_valid) begin
            base = mode ? (acc_clr ? 0 : m_acc) : longint'(psum_in);
            s = base + longint'(x_in) * m_active;
            m_p_ov = (s > MAXV) || (s < MINV);
            m_res = (s > MAXV) ? MAXV : (s < MINV) ? MINV : s;
            if (mode) m_acc = m_res;
            m_xout = x_in;
         end else if (mode && acc_clr) m_acc = 0;
         m_xv = x_valid;
         m_swo = w_swap;
         if (w_swap) m_active = m_shadow;
         if (w_load) m_shadow = w_in;
      end
   endtask

   task automatic check(string tag, longint got, longint exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_model();
      check("m_x_out", $signed(m_if.x_out), m_xout);
      check("m_x_valid_out", m_if.x_valid_out, m_xv);
      check("m_w_out", $signed(m_if.w_out), m_shadow);
      check("m_w_swap_out", m_if.w_swap_out, m_swo);
      check("m_psum_valid_out", m_if.psum_valid_out, m_pv);
      check("m_psum_out", $signed(m_if.psum_out), m_psum);
      check("m_ovf", m_if.ovf, m_ovf);
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check_model();
   endtask

   task automatic idle();
      x_valid = 0; acc_clr = 0; w_load = 0; w_swap = 0; ovf_clr = 0;
      x_in = '0; psum_in = '0;
   endtask

   task automatic beat(input int x, input int ps, input bit clr);
      idle();
      x_valid = 1; x_in = DW'(x); psum_in = AW'(ps); acc_clr = clr;
   endtask

   task automatic load(input int w, input bit swap);
      idle();
      w_load = 1; w_in = DW'(w); w_swap = swap;
   endtask

   initial begin
      longint loc_exp [4] = '{10, 25, 45, 5};
      idle();
      rst_n = 0;
      tick(); tick();
      check("rst_psum_out", $signed(m_if.psum_out), 0);
      check("rst_ovf", m_if.ovf, 0);
      check("rst_w_out", $signed(m_if.w_out), 0);
      rst_n = 1;

      load(3, 0); tick();
      idle(); w_swap = 1; tick();
      beat(5, 10, 0); tick();
      check("basic_x_out", $signed(m_if.x_out), 5);
      idle(); tick();
      check("basic_psum", $signed(m_if.psum_out), 25);
      check("basic_pvalid", m_if.psum_valid_out, 1);

      load(-2, 0); tick();
      beat(4, 0, 0); w_swap = 1; tick();
      check("dbuf_swap_out", m_if.w_swap_out, 1);
      beat(4, 0, 0); tick();
      check("dbuf_psum_old", $signed(m_if.psum_out), 12);
      idle(); tick();
      check("dbuf_psum_new", $signed(m_if.psum_out), -8);

      for (int i = 1; i <= 3; i++) begin
         load(i, 0); tick();
      end
      check("chain_w0", $signed(c0_if.w_out), 3);
      check("chain_w1", $signed(c1_if.w_out), 2);
      check("chain_w2", $signed(c2_if.w_out), 1);
      idle(); w_swap = 1; tick();
      beat(1, 0, 0); tick();
      idle(); tick();
      check("chain_act0", $signed(c0_if.psum_out), 3);
      check("chain_act1", $signed(c1_if.psum_out), 2);
      check("chain_act2", $signed(c2_if.psum_out), 1);

      load(5, 0); tick();
      idle(); w_swap = 1; tick();
      mode = 1;
      for (int i = 0; i < 6; i++) begin
         if (i == 0) beat(2, 0, 1);
         else if (i == 1) beat(3, 0, 0);
         else if (i == 2) beat(4, 0, 0);
         else if (i == 3) beat(1, 0, 1);
         else idle();
         tick();
         if (i >= 1 && i <= 4) check($sformatf("local_psum%0d", i - 1), $signed(m_if.psum_out), loc_exp[i-1]);
      end
      mode = 0;

      load(127, 0); tick();
      idle(); w_swap = 1; tick();
      beat(127, 524280, 0); tick();
      idle(); tick();
      check("ovf_sat_psum", $signed(m_if.psum_out), 524287);
      check("ovf_sat_flag", m_if.ovf, 1);
      check("ovf_wrap_psum", $signed(w_if.psum_out), -508167);
      check("ovf_wrap_flag", w_if.ovf, 1);
      idle(); ovf_clr = 1; tick();
      check("ovf_clr_sat", m_if.ovf, 0);
      check("ovf_clr_wrap", w_if.ovf, 0);
      beat(127, 524280, 0); tick();
      idle(); ovf_clr = 1; tick();
      check("ovf_wins_clr", m_if.ovf, 1);
      idle(); ovf_clr = 1; tick();
      check("ovf_clr_again", m_if.ovf, 0);

      beat(3, 1, 0); tick();
      beat(3, 1, 0); rst_n = 0; tick();
      check("rst_mid_pvalid", m_if.psum_valid_out, 0);
      check("rst_mid_psum", $signed(m_if.psum_out), 0);
      check("rst_mid_x_out", $signed(m_if.x_out), 0);
      rst_n = 1; idle(); tick();
      check("rst_mid_pvalid2", m_if.psum_valid_out, 0);
      beat(5, 7, 0); tick();
      idle(); tick();
      check("rst_active_zero", $signed(m_if.psum_out), 7);

      for (int seg = 0; seg < 10; seg++) begin
         mode = 1'($urandom_range(0, 1));
         for (int i = 0; i < 40; i++) begin
            x_valid = ($urandom_range(0, 9) < 7);
            x_in    = DW'($urandom);
            psum_in = AW'($urandom);
            acc_clr = ($urandom_range(0, 4) == 0);
            w_in    = DW'($urandom);
            w_load  = ($urandom_range(0, 9) < 3);
            w_swap  = ($urandom_range(0, 9) == 0);
            ovf_clr = ($urandom_range(0, 9) == 0);
            rst_n   = ($urandom_range(0, 99) != 0);
            tick();
         end
         rst_n = 1; idle(); tick(); tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/pe_ws_dbuf.md
# pe_ws_dbuf

Parametrised weight-stationary processing element for the matrix-multiplication coprocessor's systolic array. The current PE holds a single weight and passes sums through. This block adds:
- signed/unsigned arithmetic and a configurable accumulator width;
- a double-buffered weight (shadow/active) with a daisy-chain load path, so the next tile's weights load while the current tile streams;
- a registered `psum_valid_out` pipeline;
- a local-accumulate (output-stationary) mode;
- optional saturation with a sticky overflow flag.

## Interface
Parameters:
- DW, 16, width of data and weight.
- AW, 40, accumulator/psum width. Must satisfy AW ≥ 2·DW.
- SIGNED, 1, 1 = two's-complement operands, 0 = unsigned.
- SAT, 1, 1 = saturate sums to AW range, 0 = wrap.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- x_in  in  DW  activation.
- x_valid  in  1  x_in, psum_in and acc_clr are valid this cycle.
- psum_in  in  AW  partial sum from the upstream PE.
- acc_clr  in  1  start a new local accumulation with this beat (mode 1 only).
- mode  in  1  0 = pass-through accumulate, 1 = local accumulate. Must be static while data is in flight.
- w_in  in  DW  weight into the shadow register.
- w_load  in  1  shift w_in into shadow. This is a column broadcast.
- w_swap  in  1  copy shadow to active at the end of this cycle.
- ovf_clr  in  1  clear the sticky overflow flag.
- x_out  out  DW  registered x_in.
- x_valid_out  out  1  registered x_valid.
- w_out  out  DW  current shadow register; feeds w_in of the next PE.
- w_swap_out  out  1  registered w_swap; stays aligned with x_out.
- psum_out  out  AW  result.
- psum_valid_out  out  1  psum_out is valid.
- ovf  out  1  sticky overflow flag.

## Operation
- **Reset:** every register and output is 0, including active, shadow, accumulator and ovf. Reset mid-stream drops all in-flight beats; no valid is emitted afterwards.
- **Weight shadow:**
  - On w_load, shadow ← w_in.
  - w_out = shadow. With w_load held for N cycles across an N-deep chain, PE k ends holding w_{N-1-k}.
- **Weight swap:**
  - On w_swap, active ← old shadow.
  - If w_load and w_swap occur together, active takes the old shadow and shadow takes w_in.
  - A beat with x_valid in the swap cycle still uses the old active weight.
- **Stage 1** (edge after x_valid):
  - prod ← x_in × active, 2·DW wide, sign- or zero-extended to AW per SIGNED.
  - psum_in and acc_clr are registered; v1 ← x_valid.
  - x_out ← x_in only when x_valid; it holds otherwise. x_valid_out ← x_valid.
- **Stage 2** (edge after v1):
  - Mode 0: psum_out ← psum_r + prod.
  - Mode 1: acc ← (acc_clr_r ? 0 : acc) + prod, and psum_out ← new acc.
  - psum_valid_out ← v1. psum_out holds when v1 = 0.
  - acc_clr sampled with x_valid = 0 clears acc two cycles later and emits no valid.
- **Overflow:**
  - Overflow is judged in signed AW range (−2^(AW−1) to 2^(AW−1)−1) when SIGNED, otherwise 0 to 2^AW−1.
  - With SAT = 1 the result clamps to the bound; with SAT = 0 it wraps. In both cases ovf ← 1.
  - ovf_clr clears ovf. An overflow in the same cycle as ovf_clr wins.

## Timing
- x_out and x_valid_out: latency 1.
- psum_out and psum_valid_out: latency 2. The upstream psum must arrive in the same cycle as x_valid.
- Full throughput: one beat per cycle, no backpressure, no stalls.
- w_swap_out has latency 1, so a swap wave follows the data wavefront diagonally through the array.

## Structure
- Shared package/header pe_pkg holds MODE_PASS = 0, MODE_LOCAL = 1, and the AW ≥ 2·DW elaboration check.
- Sub-module pe_sat_add (parameters AW, SIGNED, SAT) computes the AW-bit add with clamp and overflow output. It is used in both mode paths.

## Test plan
All scenarios use DW = 8, AW = 20, SIGNED = 1, SAT = 1 unless stated otherwise.
- **Basic pass-through:** w_load 3, then w_swap; x = 5, psum_in = 10 at t → x_out = 5 at t+1, psum_out = 25 with psum_valid_out at t+2.
- **Double buffer:** active = 3, shadow = −2; beats x = 4, 4 with w_swap on the first beat → psum_out 12 then −8 (psum_in = 0). w_swap_out is high at t+1.
- **Chain load:** 3-PE column, w_load for 3 cycles with 1, 2, 3 → shadows are 3, 2, 1 from top to bottom. The following swap makes all three active simultaneously.
- **Local accumulate:** mode 1, w = 5, beats x = 2, 3, 4 with acc_clr on the first → psum_out 10, 25, 45. Next beat x = 1 with acc_clr → 5.
- **Overflow:** psum_in = 524280, x = 127, w = 127:
  - SAT = 1 → psum_out = 524287 and ovf = 1.
  - SAT = 0 → psum_out = −508167 and ovf = 1.
  - ovf_clr → 0.
- **Reset mid-stream:** beats at t and t+1, rst_n low at t+1 → no psum_valid_out at t+2 or t+3, all outputs 0, and the active weight is 0 after release.
